// File: rtl/pkt_fifo_writer.sv
// Packet ingress writer for fifo_sync: writes beats, rewinds the write pointer on
// reject/abort, and publishes commit_wptr. Optional counters: PKT_WRITER_STATS_EN.
module pkt_fifo_writer #(
  parameter int ADDR_WIDTH = 11,
  parameter int W_DATA     = 16,
  parameter int W_EL       = 18,
  parameter int MAX_BEATS  = 760,
  localparam int PTR_W     = ADDR_WIDTH + 1,
  localparam int LEN_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [W_DATA-1:0] in_data,
  input  logic              in_drop,
  output logic              fifo_wen,
  output logic [W_EL-1:0]   fifo_wdata,
  input  logic              fifo_full,
  input  logic [PTR_W-1:0]  fifo_wptr,
  output logic              fifo_wrst,
  output logic [PTR_W-1:0]  fifo_rst_wptr,
  output logic [PTR_W-1:0]  commit_wptr,
  output logic              pkt_commit,
  output logic [LEN_W-1:0]  pkt_len
`ifdef PKT_WRITER_STATS_EN
  ,
  output logic [31:0]       cnt_ok,
  output logic [31:0]       cnt_drop,
  output logic [31:0]       cnt_err
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PKT     = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_BEATS);

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0] start_ptr_q, start_ptr_d;
  logic [PTR_W-1:0] commit_wptr_q, commit_wptr_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic             pkt_commit_q, pkt_commit_d;

  logic wen, wrst, commit, ev_drop, ev_err;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    start_ptr_d = start_ptr_q;
    wen         = 1'b0;
    wrst        = 1'b0;
    commit      = 1'b0;
    ev_drop     = 1'b0;
    ev_err      = 1'b0;

    if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (in_sop) begin
            if (!fifo_full) begin
              start_ptr_d = fifo_wptr;
              beat_cnt_d  = LEN_W'(1);
              if (in_eop && in_drop) begin
                wrst    = 1'b1;
                ev_drop = 1'b1;
              end else begin
                wen = 1'b1;
                if (in_eop) commit = 1'b1;
                else        state_d = PKT;
              end
            end else begin
              ev_err = 1'b1;
              if (!in_eop) state_d = DISCARD;
            end
          end
        end

        PKT: begin
          // Abort conditions win over the filter verdict on the same beat.
          if (in_sop || fifo_full || (beat_cnt_q == MAX_CNT)) begin
            wrst    = 1'b1;
            ev_err  = 1'b1;
            state_d = (in_eop && !in_sop) ? IDLE : DISCARD;
          end else if (in_eop && in_drop) begin
            wrst    = 1'b1;
            ev_drop = 1'b1;
            state_d = IDLE;
          end else begin
            wen        = 1'b1;
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
            if (in_eop) begin
              commit  = 1'b1;
              state_d = IDLE;
            end
          end
        end

        DISCARD: begin
          if (in_eop) state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // A single-beat reject rewinds to the pointer it was sampled at, which is
  // exactly the start pointer being loaded that cycle.
  assign fifo_rst_wptr = start_ptr_d;
  assign fifo_wdata    = {in_sop, in_eop, in_data};
  assign fifo_wen      = wen  & ~reset;
  assign fifo_wrst     = wrst & ~reset;

  always_comb begin
    pkt_commit_d  = commit;
    commit_wptr_d = commit_wptr_q;
    pkt_len_d     = pkt_len_q;
    if (commit) begin
      commit_wptr_d = fifo_wptr + PTR_W'(1);
      pkt_len_d     = beat_cnt_d;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      start_ptr_q   <= '0;
      commit_wptr_q <= '0;
      pkt_len_q     <= '0;
      pkt_commit_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      start_ptr_q   <= start_ptr_d;
      commit_wptr_q <= commit_wptr_d;
      pkt_len_q     <= pkt_len_d;
      pkt_commit_q  <= pkt_commit_d;
    end
  end

  assign commit_wptr = commit_wptr_q;
  assign pkt_len     = pkt_len_q;
  assign pkt_commit  = pkt_commit_q;

`ifdef PKT_WRITER_STATS_EN
  logic [31:0] cnt_ok_q, cnt_drop_q, cnt_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_ok_q   <= '0;
      cnt_drop_q <= '0;
      cnt_err_q  <= '0;
    end else begin
      if (commit  && (cnt_ok_q   != '1)) cnt_ok_q   <= cnt_ok_q   + 32'd1;
      if (ev_drop && (cnt_drop_q != '1)) cnt_drop_q <= cnt_drop_q + 32'd1;
      if (ev_err  && (cnt_err_q  != '1)) cnt_err_q  <= cnt_err_q  + 32'd1;
    end
  end

  assign cnt_ok   = cnt_ok_q;
  assign cnt_drop = cnt_drop_q;
  assign cnt_err  = cnt_err_q;
`endif

endmodule

// File: tb/tb_pkt_fifo_writer.sv
// Directed bench for pkt_fifo_writer with a small fifo_sync write-pointer model.
module tb_pkt_fifo_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_sop, in_eop, in_drop;
  logic [15:0] in_data;
  logic        fifo_wen, fifo_wrst, fifo_full;
  logic [17:0] fifo_wdata;
  logic [11:0] fifo_wptr, fifo_rst_wptr, commit_wptr;
  logic        pkt_commit;
  logic [9:0]  pkt_len;
`ifdef PKT_WRITER_STATS_EN
  logic [31:0] cnt_ok, cnt_drop, cnt_err;
`endif

  logic        load_en;
  logic [11:0] load_val;

  int n_cmp = 0;
  int n_bad = 0;

  pkt_fifo_writer dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_data       (in_data),
    .in_drop       (in_drop),
    .fifo_wen      (fifo_wen),
    .fifo_wdata    (fifo_wdata),
    .fifo_full     (fifo_full),
    .fifo_wptr     (fifo_wptr),
    .fifo_wrst     (fifo_wrst),
    .fifo_rst_wptr (fifo_rst_wptr),
    .commit_wptr   (commit_wptr),
    .pkt_commit    (pkt_commit),
    .pkt_len       (pkt_len)
`ifdef PKT_WRITER_STATS_EN
    ,
    .cnt_ok        (cnt_ok),
    .cnt_drop      (cnt_drop),
    .cnt_err       (cnt_err)
`endif
  );

  always #5 clk = ~clk;

  // fifo_sync write pointer: reset, test preload, rewind, or advance.
  always @(posedge clk) begin
    if (reset)          fifo_wptr <= '0;
    else if (load_en)   fifo_wptr <= load_val;
    else if (fifo_wrst) fifo_wptr <= fifo_rst_wptr;
    else if (fifo_wen)  fifo_wptr <= fifo_wptr + 12'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic sop, input logic eop, input logic drop,
                      input logic full, input logic [15:0] d,
                      input logic exp_wen, input logic exp_wrst);
    @(negedge clk);
    in_valid  = 1'b1;
    in_sop    = sop;
    in_eop    = eop;
    in_drop   = drop;
    fifo_full = full;
    in_data   = d;
    #1;
    check({tag, "_wen"},   32'(fifo_wen),   32'(exp_wen));
    check({tag, "_wrst"},  32'(fifo_wrst),  32'(exp_wrst));
    check({tag, "_wdata"}, 32'(fifo_wdata), 32'({sop, eop, d}));
  endtask

  // Idles the input for one cycle and checks the registered commit outputs.
  task automatic expect_reg(input string tag, input logic commit,
                            input logic [11:0] wptr, input logic [9:0] len);
    @(negedge clk);
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_drop   = 1'b0;
    fifo_full = 1'b0;
    check({tag, "_commit"}, 32'(pkt_commit),  32'(commit));
    check({tag, "_cwptr"},  32'(commit_wptr), 32'(wptr));
    check({tag, "_len"},    32'(pkt_len),     32'(len));
  endtask

  task automatic set_wptr(input logic [11:0] v);
    @(negedge clk);
    in_valid = 1'b0;
    load_en  = 1'b1;
    load_val = v;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_drop = 1'b0;
    in_data = '0; fifo_full = 1'b0; load_en = 1'b0; load_val = '0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1; in_sop = 1'b1;
    #1;
    check("rst_wen",    32'(fifo_wen),    32'd0);
    check("rst_wrst",   32'(fifo_wrst),   32'd0);
    check("rst_commit", 32'(pkt_commit),  32'd0);
    check("rst_cwptr",  32'(commit_wptr), 32'd0);
    check("rst_len",    32'(pkt_len),     32'd0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_sop = 1'b0;

    // 4-beat accept from 0; in_drop on a middle beat must be ignored.
    beat("t1_b1", 1, 0, 0, 0, 16'hA001, 1, 0);
    check("t1_b1_wdata_k", 32'(fifo_wdata), 32'h2A001);
    beat("t1_b2", 0, 0, 1, 0, 16'hA002, 1, 0);
    beat("t1_b3", 0, 0, 0, 0, 16'hA003, 1, 0);
    beat("t1_b4", 0, 1, 0, 0, 16'hA004, 1, 0);
    check("t1_b4_wdata_k", 32'(fifo_wdata), 32'h1A004);
    expect_reg("t1_c", 1, 12'd4, 10'd4);
    expect_reg("t1_p", 0, 12'd4, 10'd4);

    // 3-beat reject from 5: rewind on the eop beat, commit_wptr untouched.
    set_wptr(12'd5);
    beat("t2_b1", 1, 0, 0, 0, 16'hB001, 1, 0);
    beat("t2_b2", 0, 0, 0, 0, 16'hB002, 1, 0);
    beat("t2_b3", 0, 1, 1, 0, 16'hB003, 0, 1);
    check("t2_rstp", 32'(fifo_rst_wptr), 32'd5);
    expect_reg("t2_c", 0, 12'd4, 10'd4);
    check("t2_wptr", 32'(fifo_wptr), 32'd5);

    // Full on beat 3 of 6: rewind to 5, rest discarded, then back in IDLE.
    beat("t3_b1", 1, 0, 0, 0, 16'hC001, 1, 0);
    beat("t3_b2", 0, 0, 0, 0, 16'hC002, 1, 0);
    beat("t3_b3", 0, 0, 0, 1, 16'hC003, 0, 1);
    check("t3_rstp", 32'(fifo_rst_wptr), 32'd5);
    beat("t3_b4", 0, 0, 0, 0, 16'hC004, 0, 0);
    beat("t3_b5", 0, 0, 0, 0, 16'hC005, 0, 0);
    beat("t3_b6", 0, 1, 0, 0, 16'hC006, 0, 0);
    beat("t3_one", 1, 1, 0, 0, 16'hC100, 1, 0);
    expect_reg("t3_c", 1, 12'd6, 10'd1);
`ifdef PKT_WRITER_STATS_EN
    check("t3_cnt_ok",   cnt_ok,   32'd2);
    check("t3_cnt_drop", cnt_drop, 32'd1);
    check("t3_cnt_err",  cnt_err,  32'd1);
`endif

    // 5-beat accept across the pointer wrap: 4094..2 written, commit at 3.
    set_wptr(12'd4094);
    for (int i = 1; i <= 5; i++)
      beat("t4", i == 1, i == 5, 0, 0, 16'(16'hD000 + i), 1, 0);
    expect_reg("t4_c", 1, 12'd3, 10'd5);

    // Exactly MAX_BEATS commits; MAX_BEATS+1 aborts on the last beat.
    for (int i = 1; i <= 760; i++)
      beat("t5a", i == 1, i == 760, 0, 0, 16'(i), 1, 0);
    expect_reg("t5a_c", 1, 12'd763, 10'd760);
    for (int i = 1; i <= 760; i++)
      beat("t5b", i == 1, 0, 0, 0, 16'(i), 1, 0);
    beat("t5b_761", 0, 1, 0, 0, 16'h0761, 0, 1);
    check("t5b_rstp", 32'(fifo_rst_wptr), 32'd763);
    expect_reg("t5b_c", 0, 12'd763, 10'd760);
    beat("t5c_b1", 1, 0, 0, 0, 16'hE001, 1, 0);
    beat("t5c_b2", 0, 1, 0, 0, 16'hE002, 1, 0);
    expect_reg("t5c_c", 1, 12'd765, 10'd2);

    // sop mid-packet: rewind to 765, the new packet is discarded too.
    beat("t6_b1", 1, 0, 0, 0, 16'hF001, 1, 0);
    beat("t6_b2", 0, 0, 0, 0, 16'hF002, 1, 0);
    beat("t6_b3", 1, 0, 0, 0, 16'hF003, 0, 1);
    check("t6_rstp", 32'(fifo_rst_wptr), 32'd765);
    beat("t6_b4", 0, 0, 0, 0, 16'hF004, 0, 0);
    beat("t6_b5", 0, 1, 0, 0, 16'hF005, 0, 0);
    expect_reg("t6_d", 0, 12'd765, 10'd2);
    beat("t6_one", 1, 1, 0, 0, 16'hF100, 1, 0);
    expect_reg("t6_c", 1, 12'd766, 10'd1);

    // sop while full: nothing written, rest of packet discarded.
    beat("t8_b1", 1, 0, 0, 1, 16'h8001, 0, 0);
    beat("t8_b2", 0, 0, 0, 0, 16'h8002, 0, 0);
    beat("t8_b3", 0, 1, 0, 0, 16'h8003, 0, 0);
    expect_reg("t8_c", 0, 12'd766, 10'd1);

    // Reset mid-packet: outputs cleared, writer back in IDLE.
    beat("t7_b1", 1, 0, 0, 0, 16'h7001, 1, 0);
    beat("t7_b2", 0, 0, 0, 0, 16'h7002, 1, 0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_sop = 1'b0;
    #1;
    check("t7_rst_wen",  32'(fifo_wen),  32'd0);
    check("t7_rst_wrst", 32'(fifo_wrst), 32'd0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    check("t7_commit", 32'(pkt_commit),  32'd0);
    check("t7_cwptr",  32'(commit_wptr), 32'd0);
    check("t7_len",    32'(pkt_len),     32'd0);
    beat("t7_frag", 0, 0, 0, 0, 16'h7003, 0, 0);
    beat("t7_drop1", 1, 1, 1, 0, 16'h7004, 0, 1);
    check("t7_rstp", 32'(fifo_rst_wptr), 32'd0);
    expect_reg("t7_d", 0, 12'd0, 10'd0);
    beat("t7_one", 1, 1, 0, 0, 16'h7005, 1, 0);
    expect_reg("t7_c", 1, 12'd1, 10'd1);
`ifdef PKT_WRITER_STATS_EN
    check("t7_cnt_ok",   cnt_ok,   32'd1);
    check("t7_cnt_drop", cnt_drop, 32'd1);
    check("t7_cnt_err",  cnt_err,  32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
